// File: rtl/ram_copy_dma_pkg.sv
// Shared types for the RAM copy DMA.
//   state_e : FSM state encoding (3 bits)
//   LAT_CW  : width of the read-latency down-counter (covers RD_LAT 1..7)
package ram_dma_pkg;

   localparam int unsigned LAT_CW = 3;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StRead  = 3'd1,
      StWait  = 3'd2,
      StWrite = 3'd3,
      StDone  = 3'd4
   } state_e;

endpackage

// File: rtl/ram_copy_dma_if.sv
// RAM port-pair bundle between the copy engine and a single RAM.
//   master : the initiator (drives strobes, addresses, write data; receives rd_data)
//   slave  : the RAM (receives strobes/addresses/write data; drives rd_data)
interface ram_copy_dma_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
) ();

   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;

   modport master (
      output rd_en, rd_addr, wr_en, wr_addr, wr_data,
      input  rd_data
   );

   modport slave (
      input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
      output rd_data
   );

endinterface

// File: rtl/ram_rd_lat_ctr.sv
// Read-latency timer for the copy engine.
//   clk, rstn : clock, asynchronous active-low reset
//   load      : restart the count (asserted in the read cycle)
//   en        : counting enabled (asserted while waiting for read data)
//   expire    : high in the RD_LAT-th waiting cycle, i.e. the cycle rd_data is captured
module ram_rd_lat_ctr
   import ram_dma_pkg::*;
#(
   parameter int unsigned RD_LAT = 1
) (
   input  logic clk,
   input  logic rstn,
   input  logic load,
   input  logic en,
   output logic expire
);

   logic [LAT_CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= LAT_CW'(RD_LAT - 1);
      end else if (en && (cnt_q != '0)) begin
         cnt_q <= cnt_q - LAT_CW'(1);
      end
   end

   assign expire = en && (cnt_q == '0);

endmodule

// File: rtl/ram_copy_dma.sv
// Word-by-word RAM-to-RAM copy engine: on an accepted start, copies len words from
// src_addr to dst_addr (ascending, addresses wrap modulo 2^AW), RD_LAT+2 cycles per word.
//   clk, rstn          : clock, asynchronous active-low reset
//   start              : request, only honoured in idle
//   src_addr, dst_addr : first source / destination word address (latched on start)
//   len                : word count (latched on start); 0 gives an immediate done
//   busy               : high while reading, waiting or writing
//   done               : one-cycle completion pulse
//   checksum           : sum of written words when RAM_COPY_CHECKSUM_EN is defined, else 0
//   ram                : RAM port pair (master side)
// Optional feature macro: RAM_COPY_CHECKSUM_EN.
module ram_copy_dma
   import ram_dma_pkg::*;
#(
   parameter int unsigned AW     = 32,
   parameter int unsigned DW     = 32,
   parameter int unsigned LW     = 16,
   parameter int unsigned RD_LAT = 1
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic           start,
   input  logic [AW-1:0]  src_addr,
   input  logic [AW-1:0]  dst_addr,
   input  logic [LW-1:0]  len,
   output logic           busy,
   output logic           done,
   output logic [DW-1:0]  checksum,
   ram_copy_dma_if.master ram
);

   state_e        state_q, state_d;
   logic [AW-1:0] src_q, dst_q;
   logic [LW-1:0] rem_q;
   logic [DW-1:0] data_q;
   logic [AW-1:0] rd_addr_q, wr_addr_q;
   logic          accept;
   logic          lat_expire;

   assign accept = (state_q == StIdle) && start;

   ram_rd_lat_ctr #(
      .RD_LAT (RD_LAT)
   ) u_lat (
      .clk    (clk),
      .rstn   (rstn),
      .load   (state_q == StRead),
      .en     (state_q == StWait),
      .expire (lat_expire)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = (len != '0) ? StRead : StDone;
            end
         end
         StRead:  state_d = StWait;
         StWait: begin
            if (lat_expire) begin
               state_d = StWrite;
            end
         end
         StWrite: state_d = (rem_q == LW'(1)) ? StDone : StRead;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // rd_addr_q/wr_addr_q remember the last strobed address so the bus holds still
   // while cur_src/cur_dst advance underneath it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         src_q     <= '0;
         dst_q     <= '0;
         rem_q     <= '0;
         data_q    <= '0;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
      end else begin
         if (accept) begin
            src_q <= src_addr;
            dst_q <= dst_addr;
            rem_q <= len;
         end
         if (state_q == StRead) begin
            rd_addr_q <= src_q;
         end
         if ((state_q == StWait) && lat_expire) begin
            data_q <= ram.rd_data;
         end
         if (state_q == StWrite) begin
            wr_addr_q <= dst_q;
            src_q     <= src_q + AW'(1);
            dst_q     <= dst_q + AW'(1);
            rem_q     <= rem_q - LW'(1);
         end
      end
   end

   assign ram.rd_en   = (state_q == StRead);
   assign ram.rd_addr = ram.rd_en ? src_q : rd_addr_q;
   assign ram.wr_en   = (state_q == StWrite);
   assign ram.wr_addr = ram.wr_en ? dst_q : wr_addr_q;
   assign ram.wr_data = data_q;

   assign busy = (state_q == StRead) || (state_q == StWait) || (state_q == StWrite);
   assign done = (state_q == StDone);

`ifdef RAM_COPY_CHECKSUM_EN
   logic [DW-1:0] csum_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         csum_q <= '0;
      end else if (accept) begin
         csum_q <= '0;
      end else if (state_q == StWrite) begin
         csum_q <= csum_q + data_q;
      end
   end

   assign checksum = csum_q;
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_ram_copy_dma.sv
// Self-checking bench for ram_copy_dma with a 1-cycle-latency RAM model.
// Expected reads/writes are queued when a copy is launched and popped by a bus monitor.
module tb_ram_copy_dma;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start = 1'b0;
   logic [31:0] src_addr = '0;
   logic [31:0] dst_addr = '0;
   logic [15:0] len = '0;
   logic        busy, done;
   logic [31:0] checksum;

   ram_copy_dma_if #(.AW(32), .DW(32)) ram_bus ();

   ram_copy_dma #(
      .AW     (32),
      .DW     (32),
      .LW     (16),
      .RD_LAT (1)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .start    (start),
      .src_addr (src_addr),
      .dst_addr (dst_addr),
      .len      (len),
      .busy     (busy),
      .done     (done),
      .checksum (checksum),
      .ram      (ram_bus)
   );

   always #5 clk = ~clk;

   // RAM model: 1024 words, address folded to 10 bits (FFFF_FFFF lands on 1023).
   logic [31:0] mem [0:1023];
   logic        pre_we = 1'b0;
   logic [9:0]  pre_wa = '0;
   logic [31:0] pre_wd = '0;

   always @(posedge clk) begin
      if (pre_we) mem[pre_wa] <= pre_wd;
      else if (ram_bus.wr_en) mem[ram_bus.wr_addr[9:0]] <= ram_bus.wr_data;
      if (ram_bus.rd_en) ram_bus.rd_data <= mem[ram_bus.rd_addr[9:0]];
   end

   int n_vec = 0;
   int n_err = 0;
   int done_cnt = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t         wr_q[$];
   logic [31:0] rd_q[$];

   always @(negedge clk) begin
      if (rstn) begin
         if (ram_bus.rd_en || ram_bus.wr_en)
            check("rd_wr_excl", 64'(ram_bus.rd_en & ram_bus.wr_en), 64'd0);
         if (ram_bus.rd_en) begin
            check("rd_expected", 64'(rd_q.size() > 0), 64'd1);
            if (rd_q.size() > 0) begin
               logic [31:0] ea;
               ea = rd_q.pop_front();
               check("rd_addr", 64'(ram_bus.rd_addr), 64'(ea));
            end
         end
         if (ram_bus.wr_en) begin
            check("wr_expected", 64'(wr_q.size() > 0), 64'd1);
            if (wr_q.size() > 0) begin
               wr_t ew;
               ew = wr_q.pop_front();
               check("wr_addr", 64'(ram_bus.wr_addr), 64'(ew.addr));
               check("wr_data", 64'(ram_bus.wr_data), 64'(ew.data));
            end
         end
         if (done) done_cnt++;
      end
   end

   task automatic preload(input logic [9:0] a, input logic [31:0] d);
      @(posedge clk);
      #1;
      pre_we = 1'b1;
      pre_wa = a;
      pre_wd = d;
   endtask

   task automatic push_copy(input logic [31:0] s, input logic [31:0] d,
                            input logic [31:0] vals[$]);
      for (int i = 0; i < vals.size(); i++) begin
         rd_q.push_back(s + 32'(i));
         wr_q.push_back('{addr: d + 32'(i), data: vals[i]});
      end
   endtask

   // Launch a copy and wait for done; lat counts cycles from start cycle to done cycle.
   task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                           input bit inject, output int lat, output int busy_n);
      @(posedge clk);
      #1;
      start = 1'b1;
      src_addr = s;
      dst_addr = d;
      len = l;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat = 1;
      busy_n = 0;
      while (!done && lat < 200) begin
         if (busy) busy_n++;
         if (inject && lat == 5) begin
            start = 1'b1;
            src_addr = 32'd0;
            dst_addr = 32'd300;
            len = 16'd1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         lat++;
      end
      start = 1'b0;
   endtask

   localparam logic [31:0] SENT = 32'hDEAD_0000;

   initial begin
      int lat, bn;
      logic [31:0] vals[$];

      #2;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_rd_en", 64'(ram_bus.rd_en), 64'd0);
      check("rst_wr_en", 64'(ram_bus.wr_en), 64'd0);
      check("rst_rd_addr", 64'(ram_bus.rd_addr), 64'd0);
      check("rst_wr_addr", 64'(ram_bus.wr_addr), 64'd0);
      check("rst_wr_data", 64'(ram_bus.wr_data), 64'd0);
      check("rst_checksum", 64'(checksum), 64'd0);

      preload(10'd10, 32'h11);
      preload(10'd11, 32'h22);
      preload(10'd12, 32'h33);
      preload(10'd13, 32'h44);
      preload(10'd1023, 32'h5A5A_0001);
      preload(10'd0, 32'h0000_A5A5);
      preload(10'd300, SENT | 32'd300);
      preload(10'd402, SENT | 32'd402);
      preload(10'd403, SENT | 32'd403);
      @(posedge clk);
      #1;
      pre_we = 1'b0;
      rstn = 1'b1;
      repeat (2) @(posedge clk);

      // Copy of 4 words with an ignored start injected mid-transfer.
      vals = '{32'h11, 32'h22, 32'h33, 32'h44};
      push_copy(32'd10, 32'd100, vals);
      run_copy(32'd10, 32'd100, 16'd4, 1'b1, lat, bn);
      check("t1_latency", 64'(lat), 64'd13);
      check("t1_busy_cycles", 64'(bn), 64'd12);
`ifdef RAM_COPY_CHECKSUM_EN
      check("t1_checksum", 64'(checksum), 64'hAA);
`else
      check("t1_checksum", 64'(checksum), 64'd0);
`endif
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) check("t1_mem", 64'(mem[100 + i]), 64'(vals[i]));
      check("t4_mem300", 64'(mem[300]), 64'(SENT | 32'd300));
      check("t4_idle", 64'(busy), 64'd0);

      // Zero length.
      run_copy(32'd10, 32'd500, 16'd0, 1'b0, lat, bn);
      check("t2_latency", 64'(lat), 64'd1);
      check("t2_busy_cycles", 64'(bn), 64'd0);
      check("t2_checksum", 64'(checksum), 64'd0);

      // Source wraps from all-ones to zero.
      repeat (2) @(posedge clk);
      rd_q.push_back(32'hFFFF_FFFF);
      rd_q.push_back(32'h0);
      wr_q.push_back('{addr: 32'd200, data: 32'h5A5A_0001});
      wr_q.push_back('{addr: 32'd201, data: 32'h0000_A5A5});
      run_copy(32'hFFFF_FFFF, 32'd200, 16'd2, 1'b0, lat, bn);
      check("t3_latency", 64'(lat), 64'd7);
`ifdef RAM_COPY_CHECKSUM_EN
      check("t3_checksum", 64'(checksum), 64'h5A5A_A5A6);
`else
      check("t3_checksum", 64'(checksum), 64'd0);
`endif
      repeat (2) @(posedge clk);
      #1;
      check("t3_mem200", 64'(mem[200]), 64'h5A5A_0001);
      check("t3_mem201", 64'(mem[201]), 64'h0000_A5A5);

      // Reset during the write of word 2: only words 0..1 land, no done.
      vals = '{32'h11, 32'h22};
      push_copy(32'd10, 32'd400, vals);
      rd_q.push_back(32'd12);
      begin
         int  dc;
         bit  hit;
         dc = done_cnt;
         hit = 1'b0;
         @(posedge clk);
         #1;
         start = 1'b1;
         src_addr = 32'd10;
         dst_addr = 32'd400;
         len = 16'd4;
         @(posedge clk);
         #1;
         start = 1'b0;
         for (int c = 0; c < 50 && !hit; c++) begin
            if (ram_bus.wr_en && ram_bus.wr_addr == 32'd402) hit = 1'b1;
            else begin
               @(posedge clk);
               #1;
            end
         end
         check("t5_reached_word2", 64'(hit), 64'd1);
         rstn = 1'b0;
         #1;
         check("t5_wr_en", 64'(ram_bus.wr_en), 64'd0);
         check("t5_busy", 64'(busy), 64'd0);
         check("t5_wr_addr", 64'(ram_bus.wr_addr), 64'd0);
         check("t5_wr_data", 64'(ram_bus.wr_data), 64'd0);
         check("t5_rd_addr", 64'(ram_bus.rd_addr), 64'd0);
         repeat (3) @(posedge clk);
         #1;
         rstn = 1'b1;
         repeat (4) @(posedge clk);
         #1;
         check("t5_mem400", 64'(mem[400]), 64'h11);
         check("t5_mem401", 64'(mem[401]), 64'h22);
         check("t5_mem402", 64'(mem[402]), 64'(SENT | 32'd402));
         check("t5_mem403", 64'(mem[403]), 64'(SENT | 32'd403));
         check("t5_no_done", 64'(done_cnt), 64'(dc));
      end

      check("rd_q_drained", 64'(rd_q.size()), 64'd0);
      check("wr_q_drained", 64'(wr_q.size()), 64'd0);
      check("done_pulses", 64'(done_cnt), 64'd3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
